// File: rtl/reg_file_sb.sv
// Register file with per-entry scoreboard (pending) bits and a registered busy count.
// Optional same-cycle write-to-read forwarding when REG_FILE_SB_BYPASS_EN is defined.

module reg_file_sb_rd #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [2**ADDR_W-1:0][DATA_W-1:0] entries,
  input  logic [2**ADDR_W-1:0]             pend,
  input  logic [ADDR_W-1:0]                rd_addr,
`ifdef REG_FILE_SB_BYPASS_EN
  input  logic                             wr_hit,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [DATA_W-1:0]                wr_data,
  input  logic                             iss_hit,
  input  logic [ADDR_W-1:0]                iss_addr,
`endif
  output logic [DATA_W-1:0]                rd_data,
  output logic                             rd_ready
);

  always_comb begin
    rd_data  = entries[rd_addr];
    rd_ready = ~pend[rd_addr];
`ifdef REG_FILE_SB_BYPASS_EN
    // forwarded data is final unless a new producer claims the same register this cycle
    if (wr_hit && (wr_addr == rd_addr)) begin
      rd_data  = wr_data;
      rd_ready = ~(iss_hit && (iss_addr == rd_addr));
    end
`endif
    if (rd_addr == '0) begin
      rd_data  = '0;
      rd_ready = 1'b1;
    end
  end

endmodule

module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_ready_a,
  output logic              rd_ready_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              flush,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH  = 2**ADDR_W;
  localparam int NPORTS = 2;

  logic [DEPTH-1:0][DATA_W-1:0]  entries;
  logic [DEPTH-1:0]              pend, pend_nxt;
  logic [ADDR_W:0]               busy_nxt;
  logic                          wr_hit, iss_hit;
  logic [NPORTS-1:0][ADDR_W-1:0] rd_addr;
  logic [NPORTS-1:0][DATA_W-1:0] rd_data;
  logic [NPORTS-1:0]             rd_ready;

  assign wr_hit  = wr_en  && (wr_addr  != '0);
  assign iss_hit = iss_en && (iss_addr != '0);

  // flush first, then write-back clears, then issue sets (newest producer wins)
  always_comb begin
    pend_nxt = flush ? '0 : pend;
    if (wr_hit)  pend_nxt[wr_addr]  = 1'b0;
    if (iss_hit) pend_nxt[iss_addr] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_comb begin
    busy_nxt = '0;
    for (int i = 1; i < DEPTH; i++)
      busy_nxt = busy_nxt + (ADDR_W+1)'(pend_nxt[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend     <= '0;
      busy_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      busy_cnt <= busy_nxt;
    end
  end

  // entry 0 is never written, so it holds its reset value of zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      entries          <= '0;
    else if (wr_hit) entries[wr_addr] <= wr_data;
  end

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;

  for (genvar p = 0; p < NPORTS; p++) begin : g_rd
    reg_file_sb_rd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
      .entries  (entries),
      .pend     (pend),
      .rd_addr  (rd_addr[p]),
`ifdef REG_FILE_SB_BYPASS_EN
      .wr_hit   (wr_hit),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_hit  (iss_hit),
      .iss_addr (iss_addr),
`endif
      .rd_data  (rd_data[p]),
      .rd_ready (rd_ready[p])
    );
  end

  assign rd_data_a  = rd_data[0];
  assign rd_data_b  = rd_data[1];
  assign rd_ready_a = rd_ready[0];
  assign rd_ready_b = rd_ready[1];

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed + random bench for reg_file_sb against an array-based scoreboard model.

module tb_reg_file_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 2**AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] rd_addr_a = '0, rd_addr_b = '0;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          rd_ready_a, rd_ready_b;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          iss_en = 1'b0;
  logic [AW-1:0] iss_addr = '0;
  logic          flush = 1'b0;
  logic [AW:0]   busy_cnt;

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_ready_a(rd_ready_a), .rd_ready_b(rd_ready_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .flush(flush), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  logic [DW-1:0] m_mem  [N];
  bit            m_pend [N];

  function automatic int m_busy();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  function automatic logic [DW-1:0] m_data(logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REG_FILE_SB_BYPASS_EN
    if (wr_en && wr_addr != 0 && wr_addr == a) return wr_data;
`endif
    return m_mem[a];
  endfunction

  function automatic logic m_ready(logic [AW-1:0] a);
    if (a == 0) return 1'b1;
`ifdef REG_FILE_SB_BYPASS_EN
    if (wr_en && wr_addr != 0 && wr_addr == a) return !(iss_en && iss_addr == a);
`endif
    return !m_pend[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (flush) for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    if (wr_en && wr_addr != 0) begin
      m_mem[wr_addr]  = wr_data;
      m_pend[wr_addr] = 1'b0;
    end
    if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_ports(string tag);
    chk({tag, ".data_a"},  64'(rd_data_a),  64'(m_data(rd_addr_a)));
    chk({tag, ".ready_a"}, 64'(rd_ready_a), 64'(m_ready(rd_addr_a)));
    chk({tag, ".data_b"},  64'(rd_data_b),  64'(m_data(rd_addr_b)));
    chk({tag, ".ready_b"}, 64'(rd_ready_b), 64'(m_ready(rd_addr_b)));
    chk({tag, ".busy"},    64'(busy_cnt),   64'(m_busy()));
  endtask

  // check combinational view, take one edge, then check the registered result
  task automatic tick(string tag);
    #1;
    check_ports({tag, ".pre"});
    @(posedge clk);
    model_edge();
    #1;
    wr_en  = 1'b0;
    iss_en = 1'b0;
    flush  = 1'b0;
    #1;
    check_ports({tag, ".post"});
  endtask

  initial begin
    model_reset();
    // controls active during reset must be ignored
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'hCAFE_F00D;
    iss_en = 1'b1; iss_addr = 7; flush = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    wr_en = 1'b0; iss_en = 1'b0;
    for (int i = 0; i < N; i++) begin
      rd_addr_a = AW'(i);
      rd_addr_b = AW'(N - 1 - i);
      #1;
      check_ports("reset");
    end
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check_ports("release");

    // writes to register 0 are dropped; a real write is visible next cycle
    rd_addr_a = 0; rd_addr_b = 0;
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'hDEAD_BEEF;
    tick("w0");
    chk("w0_lit_data", 64'(rd_data_a), 64'h0);
    chk("w0_lit_ready", 64'(rd_ready_a), 64'h1);
    rd_addr_a = 7; rd_addr_b = 7;
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'h1234_5678;
    tick("w7");
    chk("w7_lit_data", 64'(rd_data_a), 64'h1234_5678);

    // issue then write-back on register 5
    rd_addr_a = 5; rd_addr_b = 0;
    iss_en = 1'b1; iss_addr = 5;
    tick("iss5");
    chk("iss5_lit_ready", 64'(rd_ready_a), 64'h0);
    chk("iss5_lit_busy",  64'(busy_cnt),   64'h1);
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hA5A5_A5A5;
    tick("wb5");
    chk("wb5_lit_data",  64'(rd_data_a),  64'hA5A5_A5A5);
    chk("wb5_lit_ready", 64'(rd_ready_a), 64'h1);
    chk("wb5_lit_busy",  64'(busy_cnt),   64'h0);

    // issue and write on the same register: pending survives, data lands
    rd_addr_a = 9; rd_addr_b = 9;
    wr_en = 1'b1; wr_addr = 9; wr_data = 32'h0BAD_0009;
    iss_en = 1'b1; iss_addr = 9;
    tick("isswr9");
    chk("isswr9_lit_ready", 64'(rd_ready_b), 64'h0);
    chk("isswr9_lit_busy",  64'(busy_cnt),   64'h1);
    chk("isswr9_lit_data",  64'(rd_data_b),  64'h0BAD_0009);

    // fill the scoreboard, then flush while issuing register 3
    for (int i = 1; i < N; i++) begin
      rd_addr_a = AW'(i); rd_addr_b = AW'(i - 1);
      iss_en = 1'b1; iss_addr = AW'(i);
      tick("fill");
    end
    chk("fill_lit_busy", 64'(busy_cnt), 64'd31);
    flush = 1'b1; iss_en = 1'b1; iss_addr = 3;
    tick("flush");
    chk("flush_lit_busy", 64'(busy_cnt), 64'd1);
    for (int i = 0; i < N; i++) begin
      rd_addr_a = AW'(i); rd_addr_b = AW'(N - 1 - i);
      #1;
      check_ports("flushscan");
    end

    // read-during-write on register 4
    rd_addr_a = 4; rd_addr_b = 4;
    wr_en = 1'b1; wr_addr = 4; wr_data = 32'h1111_0004;
    tick("w4a");
    wr_en = 1'b1; wr_addr = 4; wr_data = 32'h0000_FFFF;
    #1;
`ifdef REG_FILE_SB_BYPASS_EN
    chk("rdw4_lit_same", 64'(rd_data_a), 64'h0000_FFFF);
`else
    chk("rdw4_lit_same", 64'(rd_data_a), 64'h1111_0004);
`endif
    tick("w4b");
    chk("rdw4_lit_next", 64'(rd_data_a), 64'h0000_FFFF);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      wr_en    = ($urandom_range(0, 1) == 1);
      wr_addr  = AW'($urandom_range(0, N - 1));
      wr_data  = DW'($urandom);
      iss_en   = ($urandom_range(0, 3) != 0);
      iss_addr = ($urandom_range(0, 5) == 0) ? wr_addr : AW'($urandom_range(0, N - 1));
      flush    = ($urandom_range(0, 15) == 0);
      rd_addr_a = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, N - 1));
      rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : AW'($urandom_range(0, N - 1));
      tick("rand");
    end

    // reset arriving mid-operation discards that cycle's write and issue
    rd_addr_a = 13; rd_addr_b = 14;
    wr_en = 1'b1; wr_addr = 12; wr_data = 32'h7777_0012;
    iss_en = 1'b1; iss_addr = 12;
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check_ports("midrst");
    @(posedge clk); #1;
    check_ports("midrst_edge");
    wr_en = 1'b0; iss_en = 1'b0;
    #1;
    reset = 1'b1;
    rd_addr_a = 12; rd_addr_b = 12;
    #1;
    check_ports("midrst_rel");
    chk("midrst_lit_data", 64'(rd_data_a), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; depth is 2**ADDR_W entries, entry 0 hardwired zero.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports rd_addr_a / rd_addr_b  input  ADDR_W  read addresses, ports A/B.
REQ-006 SHALL have ports rd_data_a / rd_data_b  output  DATA_W  read data, ports A/B.
REQ-007 SHALL have ports rd_ready_a / rd_ready_b  output  1  1 = read data is final (no producer pending).
REQ-008 SHALL have ports wr_en  input  1, wr_addr  input  ADDR_W, wr_data  input  DATA_W  write-back port.
REQ-009 SHALL have ports iss_en  input  1, iss_addr  input  ADDR_W  marks register as pending (producer issued).
REQ-010 SHALL have port flush  input  1  clears all pending marks.
REQ-011 SHALL have port busy_cnt  output  ADDR_W+1  number of pending registers.

Function
REQ-012 SHALL read combinationally: rd_data_x = entry[rd_addr_x]; address 0 always returns 0 and rd_ready_x = 1.
REQ-013 SHALL write wr_data to entry[wr_addr] on rising clk when wr_en=1 and wr_addr!=0; writes to 0 ignored.
REQ-014 SHALL keep one pending bit per entry 1..2**ADDR_W-1; bit 0 constant 0.
REQ-015 SHALL set pending[iss_addr] on rising clk when iss_en=1 and iss_addr!=0.
REQ-016 SHALL clear pending[wr_addr] on rising clk when wr_en=1 and wr_addr!=0.
REQ-017 SHALL, for iss and write to same address in same cycle, leave bit set (new producer wins); data still written.
REQ-018 SHALL, on flush=1, clear all pending bits at rising clk; iss_en in same cycle still sets its bit (flush applied first).
REQ-019 SHALL not alter stored data on flush.
REQ-020 SHALL drive rd_ready_x = ~pending[rd_addr_x], subject to REQ-012 and REQ-025.
REQ-021 SHALL register busy_cnt, equal to population count of pending bits after each edge; range 0..2**ADDR_W-1, never wraps.
REQ-022 SHALL update busy_cnt in the same edge as the pending bits (no extra latency).
REQ-023 SHALL tolerate rd_addr_a == rd_addr_b with identical outputs on both ports.

Reset
REQ-024 SHALL, while reset=0, asynchronously clear all entries to 0, all pending bits to 0, busy_cnt to 0; rd_ready_x = 1, rd_data_x = 0; reset mid-operation discards in-flight iss/write of that cycle.

Configuration
REQ-025 SHALL, with macro REG_FILE_SB_BYPASS_EN defined, forward same cycle: if wr_en=1, wr_addr!=0, wr_addr==rd_addr_x, then rd_data_x = wr_data and rd_ready_x = 1 (unless iss_en to same address is also asserted, then rd_ready_x = 0).
REQ-026 SHALL, without REG_FILE_SB_BYPASS_EN, return stored value and current pending state; written data visible from the cycle after the write edge.

Verification
REQ-027 SHALL cover: reset=0 then release; read all addresses -> data 0, ready 1, busy_cnt 0.
REQ-028 SHALL cover: write addr 0 with 0xDEADBEEF, read addr 0 -> 0x00000000, ready 1; write addr 7 0x12345678 -> next cycle read 0x12345678.
REQ-029 SHALL cover: iss addr 5 -> next cycle rd_ready 0 at addr 5, busy_cnt 1; write addr 5 0xA5A5A5A5 -> next cycle ready 1, data 0xA5A5A5A5, busy_cnt 0.
REQ-030 SHALL cover: iss and write addr 9 same cycle -> pending stays set, busy_cnt unchanged +1, data updated.
REQ-031 SHALL cover: iss addrs 1..31 -> busy_cnt 31; flush with iss addr 3 -> busy_cnt 1, only addr 3 not ready.
REQ-032 SHALL cover: read addr 4 while writing 0x0000FFFF to addr 4 -> with REG_FILE_SB_BYPASS_EN rd_data 0x0000FFFF same cycle; without, old value until next cycle.
